// File: rtl/switch_alloc_rr.sv
// switch_alloc_rr
//   Combinational all-or-nothing round-robin allocator for the multicast
//   crossbar. An input is granted only when every output in its mask is
//   free and not already claimed by an earlier winner in this scan, so a
//   multicast frame never holds a partial set of outputs (no deadlock).
//
// Ports
//   req_i      [RADIX]        request per input (mask assumed nonzero)
//   mask_i     [RADIX*RADIX]  per-input output mask, input i at [i*RADIX +: RADIX]
//   busy_i     [RADIX]        outputs currently owned by an active frame
//   rr_ptr_i   [CL_RADIX]     first input to consider this cycle
//   grant_o    [RADIX]        inputs granted this cycle
//   gnt_out_o  [RADIX]        outputs newly claimed by this cycle's grants
//   rr_ptr_o   [CL_RADIX]     first granted input + 1 (mod RADIX), else rr_ptr_i
module switch_alloc_rr #(
  parameter int unsigned RADIX    = 4,
  parameter int unsigned CL_RADIX = 2
) (
  input  logic [RADIX-1:0]       req_i,
  input  logic [RADIX*RADIX-1:0] mask_i,
  input  logic [RADIX-1:0]       busy_i,
  input  logic [CL_RADIX-1:0]    rr_ptr_i,
  output logic [RADIX-1:0]       grant_o,
  output logic [RADIX-1:0]       gnt_out_o,
  output logic [CL_RADIX-1:0]    rr_ptr_o
);

  logic [RADIX-1:0] taken;
  logic             found;
  int unsigned      pos;

  // Scan position k maps to input (rr_ptr + k) mod RADIX; the inner loop
  // keeps every index a loop constant instead of a computed select.
  always_comb begin
    taken    = busy_i;
    found    = 1'b0;
    pos      = 0;
    grant_o  = '0;
    rr_ptr_o = rr_ptr_i;
    for (int unsigned k = 0; k < RADIX; k++) begin
      pos = (32'(rr_ptr_i) + k) % RADIX;
      for (int unsigned i = 0; i < RADIX; i++) begin
        if (i == pos && req_i[i] &&
            mask_i[i*RADIX +: RADIX] != '0 &&
            (mask_i[i*RADIX +: RADIX] & taken) == '0) begin
          grant_o[i] = 1'b1;
          taken      = taken | mask_i[i*RADIX +: RADIX];
          if (!found) begin
            found    = 1'b1;
            rr_ptr_o = CL_RADIX'((i + 1) % RADIX);
          end
        end
      end
    end
    gnt_out_o = taken & ~busy_i;
  end

endmodule

// File: rtl/switch_crossbar_mc.sv
// switch_crossbar_mc
//   RADIX x RADIX AXI-Stream crossbar with frame-granular multicast. tdest
//   is an output bitmask latched at grant; the frame is replicated to every
//   output in the mask. Per-output done bits remember which outputs already
//   took the current beat, so outputs may stall independently without
//   duplicating or losing beats. A tdest of zero drains and drops the frame.
//
// Ports
//   clk, rst                  single clock, synchronous active-low reset
//   s_axis_*  [RADIX x W]     input streams (tready is an output)
//   m_axis_*  [RADIX x W]     output streams (tready is an input)
//   drop_frame [RADIX]        one-cycle pulse after a zero-mask frame's tlast
module switch_crossbar_mc #(
  parameter int unsigned RADIX            = 4,
  parameter int unsigned AXIS_DATA_WIDTH  = 64,
  parameter int unsigned AXIS_KEEP_WIDTH  = AXIS_DATA_WIDTH/8,
  parameter int unsigned AXIS_ID_ENABLE   = 1,
  parameter int unsigned AXIS_ID_WIDTH    = 8,
  parameter int unsigned AXIS_DEST_WIDTH  = RADIX,
  parameter int unsigned AXIS_USER_ENABLE = 1,
  parameter int unsigned AXIS_USER_WIDTH  = 17,
  parameter int unsigned MULTICAST_ENABLE = 1
) (
  input  logic                               clk,
  input  logic                               rst,

  input  logic [RADIX*AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [RADIX*AXIS_KEEP_WIDTH-1:0]   s_axis_tkeep,
  input  logic [RADIX-1:0]                   s_axis_tvalid,
  output logic [RADIX-1:0]                   s_axis_tready,
  input  logic [RADIX-1:0]                   s_axis_tlast,
  input  logic [RADIX*AXIS_ID_WIDTH-1:0]     s_axis_tid,
  input  logic [RADIX*AXIS_DEST_WIDTH-1:0]   s_axis_tdest,
  input  logic [RADIX*AXIS_USER_WIDTH-1:0]   s_axis_tuser,

  output logic [RADIX*AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [RADIX*AXIS_KEEP_WIDTH-1:0]   m_axis_tkeep,
  output logic [RADIX-1:0]                   m_axis_tvalid,
  input  logic [RADIX-1:0]                   m_axis_tready,
  output logic [RADIX-1:0]                   m_axis_tlast,
  output logic [RADIX*AXIS_ID_WIDTH-1:0]     m_axis_tid,
  output logic [RADIX*AXIS_DEST_WIDTH-1:0]   m_axis_tdest,
  output logic [RADIX*AXIS_USER_WIDTH-1:0]   m_axis_tuser,

  output logic [RADIX-1:0]                   drop_frame
);

  localparam int unsigned CL_RADIX = (RADIX > 1) ? $clog2(RADIX) : 1;
  localparam int unsigned DW   = AXIS_DATA_WIDTH;
  localparam int unsigned KW   = AXIS_KEEP_WIDTH;
  localparam int unsigned IW   = AXIS_ID_WIDTH;
  localparam int unsigned DSTW = AXIS_DEST_WIDTH;
  localparam int unsigned UW   = AXIS_USER_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DROP   = 2'd2
  } in_state_e;

  // Lowest set bit of a mask (two's-complement isolate).
  function automatic logic [RADIX-1:0] lowest_one(input logic [RADIX-1:0] m);
    return m & (~m + RADIX'(1));
  endfunction

  in_state_e            state_q [RADIX];
  in_state_e            state_d [RADIX];
  logic [RADIX-1:0]     mask_q  [RADIX];
  logic [RADIX-1:0]     mask_d  [RADIX];
  logic [RADIX-1:0]     done_q, done_d;
  logic [CL_RADIX-1:0]  rr_ptr_q, rr_ptr_d;
  logic [RADIX-1:0]     drop_q, drop_d;

  logic [RADIX-1:0]       mask_req [RADIX];
  logic [RADIX*RADIX-1:0] req_mask_flat;
  logic [RADIX-1:0]       req, busy;
  logic [RADIX-1:0]       grant, alloc_out;
  logic [CL_RADIX-1:0]    rr_ptr_next;
  logic [RADIX-1:0]       s_rdy, in_xfer;

  // Allocation requests from IDLE inputs; busy = outputs held by ACTIVE inputs.
  always_comb begin
    busy          = '0;
    req           = '0;
    req_mask_flat = '0;
    for (int unsigned i = 0; i < RADIX; i++) begin
      mask_req[i] = (MULTICAST_ENABLE != 0) ? s_axis_tdest[i*DSTW +: RADIX]
                                            : lowest_one(s_axis_tdest[i*DSTW +: RADIX]);
      req_mask_flat[i*RADIX +: RADIX] = mask_req[i];
      req[i] = (state_q[i] == ST_IDLE) && s_axis_tvalid[i] && (mask_req[i] != '0);
      if (state_q[i] == ST_ACTIVE) begin
        busy = busy | mask_q[i];
      end
    end
  end

  switch_alloc_rr #(
    .RADIX    (RADIX),
    .CL_RADIX (CL_RADIX)
  ) u_alloc (
    .req_i     (req),
    .mask_i    (req_mask_flat),
    .busy_i    (busy),
    .rr_ptr_i  (rr_ptr_q),
    .grant_o   (grant),
    .gnt_out_o (alloc_out),
    .rr_ptr_o  (rr_ptr_next)
  );

  // An active input advances once every targeted output has either already
  // taken the beat (done) or is taking it now.
  always_comb begin
    s_rdy   = '0;
    in_xfer = '0;
    for (int unsigned i = 0; i < RADIX; i++) begin
      case (state_q[i])
        ST_ACTIVE: s_rdy[i] = &(done_q | m_axis_tready | ~mask_q[i]);
        ST_DROP:   s_rdy[i] = 1'b1;
        default:   s_rdy[i] = 1'b0;
      endcase
      in_xfer[i] = s_axis_tvalid[i] & s_rdy[i];
    end
  end

  assign s_axis_tready = s_rdy;

  // Output muxes: each output has at most one ACTIVE owner, so the inner
  // loop selects it without a priority conflict.
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tvalid = '0;
    m_axis_tlast  = '0;
    m_axis_tid    = '0;
    m_axis_tdest  = '0;
    m_axis_tuser  = '0;
    done_d        = '0;
    for (int unsigned o = 0; o < RADIX; o++) begin
      for (int unsigned i = 0; i < RADIX; i++) begin
        if (state_q[i] == ST_ACTIVE && mask_q[i][o]) begin
          m_axis_tvalid[o]            = s_axis_tvalid[i] & ~done_q[o];
          m_axis_tdata[o*DW +: DW]    = s_axis_tdata[i*DW +: DW];
          m_axis_tkeep[o*KW +: KW]    = s_axis_tkeep[i*KW +: KW];
          m_axis_tlast[o]             = s_axis_tlast[i];
          m_axis_tdest[o*DSTW +: DSTW] = s_axis_tdest[i*DSTW +: DSTW];
          if (AXIS_ID_ENABLE != 0) begin
            m_axis_tid[o*IW +: IW] = s_axis_tid[i*IW +: IW];
          end
          if (AXIS_USER_ENABLE != 0) begin
            m_axis_tuser[o*UW +: UW] = s_axis_tuser[i*UW +: UW];
          end
          // The input transfer retires the beat everywhere; otherwise
          // remember outputs that took it so they do not see it twice.
          if (in_xfer[i]) begin
            done_d[o] = 1'b0;
          end else if (s_axis_tvalid[i] && !done_q[o] && m_axis_tready[o]) begin
            done_d[o] = 1'b1;
          end else begin
            done_d[o] = done_q[o];
          end
        end
      end
      if (alloc_out[o]) begin
        done_d[o] = 1'b0;
      end
    end
  end

  // Per-input frame state.
  always_comb begin
    rr_ptr_d = rr_ptr_next;
    drop_d   = '0;
    for (int unsigned i = 0; i < RADIX; i++) begin
      state_d[i] = state_q[i];
      mask_d[i]  = mask_q[i];
      case (state_q[i])
        ST_IDLE: begin
          if (grant[i]) begin
            state_d[i] = ST_ACTIVE;
            mask_d[i]  = mask_req[i];
          end else if (s_axis_tvalid[i] && mask_req[i] == '0) begin
            state_d[i] = ST_DROP;
          end
        end
        ST_ACTIVE: begin
          if (in_xfer[i] && s_axis_tlast[i]) begin
            state_d[i] = ST_IDLE;
            mask_d[i]  = '0;
          end
        end
        ST_DROP: begin
          if (in_xfer[i] && s_axis_tlast[i]) begin
            state_d[i] = ST_IDLE;
            drop_d[i]  = 1'b1;
          end
        end
        default: state_d[i] = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < RADIX; i++) begin
        state_q[i] <= ST_IDLE;
        mask_q[i]  <= '0;
      end
      done_q   <= '0;
      rr_ptr_q <= '0;
      drop_q   <= '0;
    end else begin
      for (int unsigned i = 0; i < RADIX; i++) begin
        state_q[i] <= state_d[i];
        mask_q[i]  <= mask_d[i];
      end
      done_q   <= done_d;
      rr_ptr_q <= rr_ptr_d;
      drop_q   <= drop_d;
    end
  end

  assign drop_frame = drop_q;

endmodule

// File: tb/tb_switch_crossbar_mc.sv
module tb_switch_crossbar_mc;

  localparam int R   = 4;
  localparam int DW  = 64;
  localparam int KW  = 8;
  localparam int IW  = 8;
  localparam int DSW = 4;
  localparam int UW  = 17;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [R*DW-1:0]  s_axis_tdata,  m_axis_tdata;
  logic [R*KW-1:0]  s_axis_tkeep,  m_axis_tkeep;
  logic [R-1:0]     s_axis_tvalid, m_axis_tvalid;
  logic [R-1:0]     s_axis_tready, m_axis_tready;
  logic [R-1:0]     s_axis_tlast,  m_axis_tlast;
  logic [R*IW-1:0]  s_axis_tid,    m_axis_tid;
  logic [R*DSW-1:0] s_axis_tdest,  m_axis_tdest;
  logic [R*UW-1:0]  s_axis_tuser,  m_axis_tuser;
  logic [R-1:0]     drop_frame;

  logic [DW-1:0]  sd   [R];
  logic [KW-1:0]  sk   [R];
  logic           sv   [R];
  logic           sl   [R];
  logic [IW-1:0]  si   [R];
  logic [DSW-1:0] sdst [R];
  logic [UW-1:0]  su   [R];
  logic           mr   [R];
  logic           srdy [R];

  for (genvar g = 0; g < R; g++) begin : g_flat
    assign s_axis_tdata[g*DW +: DW]   = sd[g];
    assign s_axis_tkeep[g*KW +: KW]   = sk[g];
    assign s_axis_tvalid[g]           = sv[g];
    assign s_axis_tlast[g]            = sl[g];
    assign s_axis_tid[g*IW +: IW]     = si[g];
    assign s_axis_tdest[g*DSW +: DSW] = sdst[g];
    assign s_axis_tuser[g*UW +: UW]   = su[g];
    assign m_axis_tready[g]           = mr[g];
    assign srdy[g]                    = s_axis_tready[g];
  end

  switch_crossbar_mc #(
    .RADIX            (R),
    .AXIS_DATA_WIDTH  (DW),
    .AXIS_KEEP_WIDTH  (KW),
    .AXIS_ID_ENABLE   (1),
    .AXIS_ID_WIDTH    (IW),
    .AXIS_DEST_WIDTH  (DSW),
    .AXIS_USER_ENABLE (1),
    .AXIS_USER_WIDTH  (UW),
    .MULTICAST_ENABLE (1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tid    (s_axis_tid),
    .s_axis_tdest  (s_axis_tdest),
    .s_axis_tuser  (s_axis_tuser),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tid    (m_axis_tid),
    .m_axis_tdest  (m_axis_tdest),
    .m_axis_tuser  (m_axis_tuser),
    .drop_frame    (drop_frame)
  );

  typedef struct {
    int             port;
    int             cyc;
    logic [DW-1:0]  data;
    logic [KW-1:0]  keep;
    logic           last;
    logic [IW-1:0]  id;
    logic [DSW-1:0] dest;
    logic [UW-1:0]  user;
  } beat_t;

  beat_t    mq[$];
  beat_t    mb;
  int       cyc = 0;
  int       n_pass = 0;
  int       n_chk = 0;
  logic [R-1:0] srdy_h [0:4095];
  logic [R-1:0] mvld_h [0:4095];
  logic [R-1:0] drop_h [0:4095];

  always @(posedge clk) cyc <= cyc + 1;

  // Observe mid-cycle: a beat seen valid&ready here transfers at the next edge.
  always @(negedge clk) begin
    if (cyc < 4096) begin
      srdy_h[cyc] = s_axis_tready;
      mvld_h[cyc] = m_axis_tvalid;
      drop_h[cyc] = drop_frame;
    end
    for (int o = 0; o < R; o++) begin
      if (m_axis_tvalid[o] && m_axis_tready[o]) begin
        mb.port = o;
        mb.cyc  = cyc;
        mb.data = m_axis_tdata[o*DW +: DW];
        mb.keep = m_axis_tkeep[o*KW +: KW];
        mb.last = m_axis_tlast[o];
        mb.id   = m_axis_tid[o*IW +: IW];
        mb.dest = m_axis_tdest[o*DSW +: DSW];
        mb.user = m_axis_tuser[o*UW +: UW];
        mq.push_back(mb);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, required finish");
    $fatal(1);
  end

  function automatic logic [DW-1:0] exp_data(input int p, input logic [7:0] tag, input int b);
    return {tag, 8'(p), 16'h0, 32'(b)};
  endfunction

  function automatic int count_port(input int o);
    int n = 0;
    foreach (mq[k]) if (mq[k].port == o) n++;
    return n;
  endfunction

  function automatic beat_t nth_beat(input int o, input int n);
    beat_t r;
    int    c = 0;
    r.port = -1; r.cyc = -1; r.data = '0; r.keep = '0; r.last = 1'b0;
    r.id = '0; r.dest = '0; r.user = '0;
    foreach (mq[k]) begin
      if (mq[k].port == o) begin
        if (c == n) return mq[k];
        c++;
      end
    end
    return r;
  endfunction

  // Called just after a rising edge; returns just after the edge that
  // completed the last beat.
  task automatic send_frame(input int p, input int n, input logic [3:0] dest,
                            input logic [7:0] tag, output int t0);
    logic acc;
    int   budget;
    t0 = cyc;
    for (int b = 0; b < n; b++) begin
      sv[p]   = 1'b1;
      sd[p]   = exp_data(p, tag, b);
      sk[p]   = (b == n-1) ? 8'h0F : 8'hFF;
      sl[p]   = (b == n-1);
      si[p]   = tag;
      sdst[p] = dest;
      su[p]   = {9'h100, tag};
      budget  = 0;
      acc     = 1'b0;
      while (!acc && budget < 200) begin
        @(negedge clk);
        acc = srdy[p];
        @(posedge clk);
        #1;
        budget++;
      end
      if (!acc) begin
        n_chk++;
        $display("FAIL handshake p%0d beat %0d: tready not seen in 200 cycles, required 1", p, b);
        sv[p] = 1'b0;
        sl[p] = 1'b0;
        return;
      end
    end
    sv[p] = 1'b0;
    sl[p] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    for (int i = 0; i < R; i++) begin
      sv[i] = 1'b0; sl[i] = 1'b0; mr[i] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    mq.delete();
  endtask

  task automatic test_reset();
    for (int i = 0; i < R; i++) begin
      sv[i] = 1'b0; sl[i] = 1'b0; mr[i] = 1'b1;
      sd[i] = '0; sk[i] = '0; si[i] = '0; sdst[i] = '0; su[i] = '0;
    end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (m_axis_tvalid !== 4'b0000) $display("FAIL reset_mvalid: got %b required 0000", m_axis_tvalid);
    else n_pass++;
    n_chk++;
    if (s_axis_tready !== 4'b0000) $display("FAIL reset_sready: got %b required 0000", s_axis_tready);
    else n_pass++;
    n_chk++;
    if (drop_frame !== 4'b0000) $display("FAIL reset_drop: got %b required 0000", drop_frame);
    else n_pass++;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_unicast();
    int t0;
    beat_t bt;
    logic [R-1:0] vor;
    do_reset();
    send_frame(0, 3, 4'b0010, 8'h11, t0);
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (count_port(1) != 3) $display("FAIL uni_count: got %0d beats on m1 required 3", count_port(1));
    else n_pass++;
    for (int b = 0; b < 3; b++) begin
      bt = nth_beat(1, b);
      n_chk++;
      if (bt.cyc != t0 + 1 + b) $display("FAIL uni_cycle b%0d: got %0d required %0d", b, bt.cyc, t0 + 1 + b);
      else n_pass++;
      n_chk++;
      if ({bt.data, bt.keep, bt.last, bt.id, bt.dest, bt.user} !==
          {exp_data(0, 8'h11, b), (b == 2) ? 8'h0F : 8'hFF, (b == 2), 8'h11, 4'b0010, 17'h10011})
        $display("FAIL uni_fields b%0d: got data=%h keep=%h last=%b id=%h dest=%b user=%h required data=%h keep=%h last=%b id=11 dest=0010 user=10011",
                 b, bt.data, bt.keep, bt.last, bt.id, bt.dest, bt.user,
                 exp_data(0, 8'h11, b), (b == 2) ? 8'h0F : 8'hFF, (b == 2));
      else n_pass++;
    end
    vor = '0;
    for (int c = t0; c <= t0 + 5; c++) vor = vor | mvld_h[c];
    n_chk++;
    if ((vor & 4'b1101) !== 4'b0000) $display("FAIL uni_other_valid: got %b required 0000", vor & 4'b1101);
    else n_pass++;
  endtask

  task automatic test_contention();
    int ta, tb, tc;
    beat_t bt;
    int    src [9];
    logic [7:0] tg [9];
    int    ec  [9];
    int    bi  [9];
    do_reset();
    fork
      begin
        send_frame(0, 3, 4'b0100, 8'hA0, ta);
        send_frame(0, 3, 4'b0100, 8'hC0, tc);
      end
      send_frame(1, 3, 4'b0100, 8'hB0, tb);
    join
    repeat (2) @(posedge clk);
    #1;
    // A on m2 at ta+1..3, bubble, B at ta+5..7, bubble, C at ta+9..11
    for (int k = 0; k < 9; k++) begin
      src[k] = (k / 3 == 1) ? 1 : 0;
      tg[k]  = (k / 3 == 0) ? 8'hA0 : (k / 3 == 1) ? 8'hB0 : 8'hC0;
      ec[k]  = ta + 1 + k + 2 * (k / 3) - (k / 3 == 0 ? 0 : 0);
      ec[k]  = ta + 1 + (k % 3) + 4 * (k / 3);
      bi[k]  = k % 3;
    end
    n_chk++;
    if (count_port(2) != 9) $display("FAIL cont_count: got %0d beats on m2 required 9", count_port(2));
    else n_pass++;
    for (int k = 0; k < 9; k++) begin
      bt = nth_beat(2, k);
      n_chk++;
      if (bt.data !== exp_data(src[k], tg[k], bi[k]))
        $display("FAIL cont_order k%0d: got %h required %h", k, bt.data, exp_data(src[k], tg[k], bi[k]));
      else n_pass++;
      n_chk++;
      if (bt.cyc != ec[k]) $display("FAIL cont_cycle k%0d: got %0d required %0d", k, bt.cyc, ec[k]);
      else n_pass++;
    end
  endtask

  task automatic test_mcast_stall();
    int t0;
    beat_t bt;
    logic [4:0] rtrace;
    do_reset();
    mr[1] = 1'b0;
    fork
      begin
        repeat (4) @(posedge clk);
        #1 mr[1] = 1'b1;
      end
      send_frame(0, 2, 4'b1011, 8'h5A, t0);
    join
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if ({8'(count_port(0)), 8'(count_port(1)), 8'(count_port(2)), 8'(count_port(3))} !== {8'd2, 8'd2, 8'd0, 8'd2})
      $display("FAIL mc_counts: got m0=%0d m1=%0d m2=%0d m3=%0d required 2 2 0 2",
               count_port(0), count_port(1), count_port(2), count_port(3));
    else n_pass++;
    bt = nth_beat(0, 0);
    n_chk++;
    if (bt.cyc != t0 + 1 || bt.data !== exp_data(0, 8'h5A, 0))
      $display("FAIL mc_m0_b0: got cyc=%0d data=%h required cyc=%0d data=%h", bt.cyc, bt.data, t0 + 1, exp_data(0, 8'h5A, 0));
    else n_pass++;
    bt = nth_beat(3, 0);
    n_chk++;
    if (bt.cyc != t0 + 1 || bt.data !== exp_data(0, 8'h5A, 0))
      $display("FAIL mc_m3_b0: got cyc=%0d data=%h required cyc=%0d data=%h", bt.cyc, bt.data, t0 + 1, exp_data(0, 8'h5A, 0));
    else n_pass++;
    bt = nth_beat(1, 0);
    n_chk++;
    if (bt.cyc != t0 + 4 || bt.data !== exp_data(0, 8'h5A, 0))
      $display("FAIL mc_m1_b0: got cyc=%0d data=%h required cyc=%0d data=%h", bt.cyc, bt.data, t0 + 4, exp_data(0, 8'h5A, 0));
    else n_pass++;
    bt = nth_beat(0, 1);
    n_chk++;
    if (bt.cyc != t0 + 5 || bt.data !== exp_data(0, 8'h5A, 1) || bt.last !== 1'b1)
      $display("FAIL mc_m0_b1: got cyc=%0d data=%h last=%b required cyc=%0d data=%h last=1",
               bt.cyc, bt.data, bt.last, t0 + 5, exp_data(0, 8'h5A, 1));
    else n_pass++;
    for (int k = 0; k < 5; k++) rtrace[k] = srdy_h[t0 + 1 + k][0];
    n_chk++;
    if (rtrace !== 5'b11000) $display("FAIL mc_sready_trace: got %b required 11000 (cycles N+5..N+1)", rtrace);
    else n_pass++;
  endtask

  task automatic test_deadlock();
    int t0, t1, t2;
    beat_t bt;
    do_reset();
    fork
      send_frame(0, 3, 4'b0011, 8'hD0, t0);
      send_frame(1, 2, 4'b0110, 8'hD1, t1);
      send_frame(2, 2, 4'b1000, 8'hD2, t2);
    join
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if ({8'(count_port(0)), 8'(count_port(1)), 8'(count_port(2)), 8'(count_port(3))} !== {8'd3, 8'd5, 8'd2, 8'd2})
      $display("FAIL dl_counts: got m0=%0d m1=%0d m2=%0d m3=%0d required 3 5 2 2",
               count_port(0), count_port(1), count_port(2), count_port(3));
    else n_pass++;
    bt = nth_beat(0, 0);
    n_chk++;
    if (bt.cyc != t0 + 1 || bt.data !== exp_data(0, 8'hD0, 0))
      $display("FAIL dl_in0_grant: got cyc=%0d data=%h required cyc=%0d data=%h", bt.cyc, bt.data, t0 + 1, exp_data(0, 8'hD0, 0));
    else n_pass++;
    bt = nth_beat(3, 0);
    n_chk++;
    if (bt.cyc != t0 + 1 || bt.data !== exp_data(2, 8'hD2, 0))
      $display("FAIL dl_in2_grant: got cyc=%0d data=%h required cyc=%0d data=%h", bt.cyc, bt.data, t0 + 1, exp_data(2, 8'hD2, 0));
    else n_pass++;
    bt = nth_beat(1, 3);
    n_chk++;
    if (bt.cyc != t0 + 5 || bt.data !== exp_data(1, 8'hD1, 0))
      $display("FAIL dl_in1_m1: got cyc=%0d data=%h required cyc=%0d data=%h", bt.cyc, bt.data, t0 + 5, exp_data(1, 8'hD1, 0));
    else n_pass++;
    bt = nth_beat(2, 1);
    n_chk++;
    if (bt.cyc != t0 + 6 || bt.data !== exp_data(1, 8'hD1, 1) || bt.last !== 1'b1)
      $display("FAIL dl_in1_m2_last: got cyc=%0d data=%h last=%b required cyc=%0d data=%h last=1",
               bt.cyc, bt.data, bt.last, t0 + 6, exp_data(1, 8'hD1, 1));
    else n_pass++;
  endtask

  task automatic test_drop();
    int t0;
    logic [5:0] rtrace;
    logic [R-1:0] vor;
    int ndrop;
    do_reset();
    send_frame(3, 4, 4'b0000, 8'hE3, t0);
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 6; k++) rtrace[k] = srdy_h[t0 + k][3];
    n_chk++;
    if (rtrace !== 6'b011110) $display("FAIL drop_sready_trace: got %b required 011110 (cycles N+5..N)", rtrace);
    else n_pass++;
    n_chk++;
    if (drop_h[t0 + 5] !== 4'b1000) $display("FAIL drop_pulse: got %b required 1000", drop_h[t0 + 5]);
    else n_pass++;
    ndrop = 0;
    vor = '0;
    for (int c = t0; c <= t0 + 7; c++) begin
      ndrop += int'(drop_h[c][3]);
      vor = vor | mvld_h[c];
    end
    n_chk++;
    if (ndrop != 1) $display("FAIL drop_count: got %0d pulses required 1", ndrop);
    else n_pass++;
    n_chk++;
    if (vor !== 4'b0000 || mq.size() != 0)
      $display("FAIL drop_no_output: got valid_or=%b beats=%0d required 0000 and 0", vor, mq.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int ta, tb;
    beat_t bt;
    do_reset();
    sv[0] = 1'b1; sdst[0] = 4'b0101; si[0] = 8'h77; su[0] = 17'h10077;
    sd[0] = exp_data(0, 8'h77, 0); sk[0] = 8'hFF; sl[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    sd[0] = exp_data(0, 8'h77, 1);
    @(posedge clk); #1;
    sd[0] = exp_data(0, 8'h77, 2);
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if (m_axis_tvalid !== 4'b0101) $display("FAIL rm_inflight: got %b required 0101", m_axis_tvalid);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (m_axis_tvalid !== 4'b0000) $display("FAIL rm_mvalid: got %b required 0000", m_axis_tvalid);
    else n_pass++;
    n_chk++;
    if (s_axis_tready !== 4'b0000) $display("FAIL rm_sready: got %b required 0000", s_axis_tready);
    else n_pass++;
    sv[0] = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    mq.delete();
    fork
      send_frame(0, 1, 4'b0010, 8'h80, ta);
      send_frame(1, 1, 4'b0010, 8'h81, tb);
    join
    repeat (3) @(posedge clk);
    #1;
    bt = nth_beat(1, 0);
    n_chk++;
    if (bt.cyc != ta + 1 || bt.data !== exp_data(0, 8'h80, 0))
      $display("FAIL rm_first: got cyc=%0d data=%h required cyc=%0d data=%h", bt.cyc, bt.data, ta + 1, exp_data(0, 8'h80, 0));
    else n_pass++;
    bt = nth_beat(1, 1);
    n_chk++;
    if (bt.cyc != ta + 3 || bt.data !== exp_data(1, 8'h81, 0))
      $display("FAIL rm_second: got cyc=%0d data=%h required cyc=%0d data=%h", bt.cyc, bt.data, ta + 3, exp_data(1, 8'h81, 0));
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_unicast();
    test_contention();
    test_mcast_stall();
    test_deadlock();
    test_drop();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
